pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Arbitrates the single-port program memory between the IF-stage fetch path and the debug/UART program loader.
//  Sequences ownership of the memory with an FSM, drains in-flight reads and holds the PC while the loader owns memory.
//  Returns fetched words tagged with a valid strobe.
//  Sits between stage_if/pc and the pmem BRAM instance.
// PARAMETERS
//  DATA_W       32  instruction/data word width
//  MEM_AW       10  pmem word-address width (depth 2**MEM_AW)
//  MEM_LATENCY  1   pmem read latency in cycles (1..3)
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       reset, synchronous, active-high
//  fetch_req    in   1       IF requests word at fetch_addr this cycle
//  fetch_addr   in   32      byte address from PC
//  fetch_data   out  DATA_W  fetched instruction
//  fetch_valid  out  1       fetch_data valid this cycle
//  cpu_hold     out  1       freeze PC / IF (loader owns or drain in progress)
//  load_req     in   1       loader requests ownership / write
//  load_addr    in   MEM_AW  word address to write
//  load_data    in   DATA_W  word to write
//  load_we      in   1       write strobe (honoured only in LOAD)
//  load_ack     out  1       write accepted this cycle
//  load_done    in   1       loader releases memory (single-cycle pulse)
//  mem_en       out  1       pmem enable
//  mem_we       out  1       pmem write enable
//  mem_addr     out  MEM_AW  pmem address
//  mem_wdata    out  DATA_W  pmem write data
//  mem_rdata    in   DATA_W  pmem read data
// BEHAVIOUR
//  Reset values
//   - all outputs 0; FSM -> IDLE; read-valid pipe cleared.
//   - reset mid-load abandons the load; already-written words remain in memory.
//  FSM states: IDLE, FETCH, DRAIN, LOAD.
//   IDLE : load_req -> LOAD; else fetch_req -> FETCH (issues the read the same cycle).
//   FETCH: load_req -> DRAIN; else stay. With no request, stays in FETCH with mem_en=0.
//   DRAIN: no new reads; stays until the valid pipe is empty (MEM_LATENCY cycles), then -> LOAD.
//   LOAD : loader owns memory. load_done -> IDLE (load_done has priority over load_we in the same cycle).
//  Priority
//   - loader wins over fetch.
//   - load_req and fetch_req both high in IDLE -> LOAD, and the fetch is not issued.
//  Fetch path
//   - mem_addr = fetch_addr[MEM_AW+1:2]; fetch_addr[1:0] ignored.
//   - the upper address bits wrap silently (no fault).
//   - read issued when state is IDLE/FETCH, fetch_req=1 and load_req=0.
//   - fetch_valid asserts exactly MEM_LATENCY cycles after issue, with fetch_data = mem_rdata; back-to-back issue gives 1 word/cycle.
//   - fetch_data holds its last value when fetch_valid=0.
//  Load path
//   - in LOAD, load_we=1 -> mem_en=1, mem_we=1, mem_addr=load_addr, mem_wdata=load_data.
//   - load_ack is registered: high the cycle after the write is issued.
//   - load_we outside LOAD is ignored (no ack).
//  cpu_hold
//   - asserted combinationally in DRAIN, in LOAD, and in IDLE/FETCH whenever load_req=1.
//   - deasserts the cycle after load_done.
//  mem_we is never 1 outside LOAD. Reads still in flight are always delivered, never dropped.
// STRUCTURE
//  Shared package mips_pkg: FSM state encodings (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, LOAD=2'd3) and DATA_W default.
//  One sub-module: read_valid_pipe (MEM_LATENCY-deep shift register of issue strobes, with an empty flag).
//  Remaining logic (FSM, mux, ack register) stays inline.
// TESTING
//  1. reset, then fetch_req=1 at addresses 0x0,0x4,0x8 on consecutive cycles -> mem_addr 0,1,2; fetch_valid 1 cycle later per word, data matches preloaded words.
//  2. load_req during a streaming fetch (MEM_LATENCY=2) -> cpu_hold high the same cycle; 2 DRAIN cycles deliver both outstanding words; then LOAD.
//  3. in LOAD write 0xDEADBEEF to addr 5, then load_done -> load_ack 1 cycle after the write; cpu_hold drops; fetch of 0x14 returns 0xDEADBEEF.
//  4. load_req and fetch_req high together in IDLE -> state LOAD, mem_we only for load, no fetch_valid produced.
//  5. reset asserted mid-LOAD after 3 of 6 writes -> outputs 0, IDLE; the first 3 words persist and the remaining 3 are unchanged.
//  6. fetch_addr 0x0000_1004 with MEM_AW=10 -> mem_addr wraps to 1; load_we asserted in FETCH -> no write, load_ack stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the program-memory arbiter
//
// Purpose: ownership-FSM state encodings and the default instruction word width.
// Ports:   none (package).

package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_LOAD  = 2'd3
   } pmem_state_t;

   localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/pmem_arbiter_read_valid_pipe.sv
// rtl/pmem_arbiter_read_valid_pipe.sv - issue-strobe delay line matching pmem read latency
//
// Purpose: delays each read-issue strobe by DEPTH cycles so it lines up with the
//          returning pmem word, and reports when no read is still in flight.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high; clears every in-flight strobe
//   issue  in   a read was issued to pmem this cycle
//   valid  out  the read issued DEPTH cycles ago returns this cycle
//   empty  out  no read in flight

module read_valid_pipe #(
   parameter int DEPTH = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic issue,
   output logic valid,
   output logic empty
);

   logic [DEPTH-1:0] pipe;

   always_ff @(posedge clock) begin
      if (reset) begin
         pipe <= '0;
      end else begin
         pipe[0] <= issue;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign valid = pipe[DEPTH-1];
   assign empty = (pipe == '0);

endmodule

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - single-port program memory arbiter between IF fetch and the program loader
//
// Purpose: hands the pmem port to either the IF fetch path or the loader. The loader
//          always wins; before it gets the port, reads already issued are drained so
//          no fetched word is lost, and the PC is held for the whole hand-over.
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   fetch_req, fetch_addr             IF read request and PC byte address
//   fetch_data, fetch_valid           returned word and its strobe (data holds between strobes)
//   cpu_hold                          freeze PC / IF
//   load_req, load_addr, load_data    loader ownership request and write word/address
//   load_we, load_ack, load_done      write strobe, registered accept, release pulse
//   mem_en, mem_we, mem_addr          pmem control
//   mem_wdata, mem_rdata              pmem data

module pmem_arbiter import mips_pkg::*; #(
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int MEM_AW      = 10,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   output logic              cpu_hold,
   input  logic              load_req,
   input  logic [MEM_AW-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_we,
   output logic              load_ack,
   input  logic              load_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   pmem_state_t       state;
   pmem_state_t       state_next;
   logic              issue_rd;
   logic              issue_wr;
   logic              pipe_valid;
   logic              pipe_empty;
   logic              ack_q;
   logic [DATA_W-1:0] data_hold;

   // Byte-offset bits and address bits above the memory depth are dropped on purpose:
   // the fetch address wraps silently within pmem.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{fetch_addr[31:MEM_AW+2], fetch_addr[1:0]};

   // A pending loader request suppresses the fetch in the same cycle.
   assign issue_rd = !reset && (state == ST_IDLE || state == ST_FETCH)
                     && fetch_req && !load_req;
   // load_done releases the port and takes priority over a simultaneous write.
   assign issue_wr = !reset && (state == ST_LOAD) && load_we && !load_done;

   read_valid_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_read_valid_pipe (
      .clock (clock),
      .reset (reset),
      .issue (issue_rd),
      .valid (pipe_valid),
      .empty (pipe_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (load_req) begin
               state_next = ST_LOAD;
            end else if (fetch_req) begin
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (load_req) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (load_done) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_hold  = 1'b0;
      if (!reset) begin
         cpu_hold = (state == ST_DRAIN) || (state == ST_LOAD) || load_req;
         if (issue_wr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = load_addr;
            mem_wdata = load_data;
         end else if (issue_rd) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr[MEM_AW+1:2];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ack_q     <= 1'b0;
         data_hold <= '0;
      end else begin
         ack_q <= issue_wr;
         if (pipe_valid) begin
            data_hold <= mem_rdata;
         end
      end
   end

   // The returning word is passed straight through so it appears exactly
   // MEM_LATENCY cycles after issue; the hold register only covers idle cycles.
   assign fetch_valid = pipe_valid && !reset;
   assign fetch_data  = reset ? '0 : (pipe_valid ? mem_rdata : data_hold);
   assign load_ack    = ack_q && !reset;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter with a two-cycle pmem

module tb_pmem_arbiter;

   localparam int LAT   = 2;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_DRAIN = 2;
   localparam int M_LOAD  = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic          fetch_req;
   logic [31:0]   fetch_addr;
   logic [31:0]   fetch_data;
   logic          fetch_valid;
   logic          cpu_hold;
   logic          load_req;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;
   logic          load_we;
   logic          load_ack;
   logic          load_done;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   int nchk = 0;
   int nerr = 0;

   always #5 clock = ~clock;

   pmem_arbiter #(
      .DATA_W      (32),
      .MEM_AW      (AW),
      .MEM_LATENCY (LAT)
   ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_data  (fetch_data),
      .fetch_valid (fetch_valid),
      .cpu_hold    (cpu_hold),
      .load_req    (load_req),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .load_we     (load_we),
      .load_ack    (load_ack),
      .load_done   (load_done),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // pmem: two-cycle registered read, preloaded on the first edge
   logic [31:0] bram [DEPTH];
   logic [31:0] rd_s0 = '0;
   logic [31:0] rd_s1 = '0;
   logic        bram_ready = 1'b0;

   always @(posedge clock) begin
      if (!bram_ready) begin
         for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
         bram_ready <= 1'b1;
      end else if (mem_en && mem_we) begin
         bram[mem_addr] <= mem_wdata;
      end else if (mem_en) begin
         rd_s0 <= bram[mem_addr];
      end
      rd_s1 <= rd_s0;
   end
   assign mem_rdata = rd_s1;

   // Reference model: ownership mode, queue of outstanding reads with their due
   // cycle and the word they must return, and an image of memory contents.
   typedef struct {
      int          due;
      logic [31:0] data;
   } rd_t;

   rd_t         inflight[$];
   logic [31:0] ref_mem [DEPTH];
   int          cyc = 0;
   int          mode = M_IDLE;
   logic [31:0] last_data = '0;
   logic        ack_exp = 1'b0;
   logic        model_ready = 1'b0;

   always @(negedge clock) begin
      logic        iss;
      logic        wr;
      logic        ev;
      logic        no_reads;
      logic        hold;
      logic [31:0] ed;
      if (!model_ready) begin
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
         model_ready = 1'b1;
      end
      if (reset) begin
         chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
         chk("rst_fetch_data",  fetch_data, 32'd0);
         chk("rst_cpu_hold",    32'(cpu_hold), 32'd0);
         chk("rst_load_ack",    32'(load_ack), 32'd0);
         chk("rst_mem_en",      32'(mem_en), 32'd0);
         chk("rst_mem_we",      32'(mem_we), 32'd0);
         chk("rst_mem_addr",    32'(mem_addr), 32'd0);
         chk("rst_mem_wdata",   mem_wdata, 32'd0);
         mode      = M_IDLE;
         inflight.delete();
         last_data = '0;
         ack_exp   = 1'b0;
      end else begin
         iss  = (mode == M_IDLE || mode == M_FETCH) && fetch_req && !load_req;
         wr   = (mode == M_LOAD) && load_we && !load_done;
         ev   = (inflight.size() != 0) && (inflight[0].due == cyc);
         ed   = ev ? inflight[0].data : last_data;
         hold = (mode == M_DRAIN) || (mode == M_LOAD) || load_req;
         chk("fetch_valid", 32'(fetch_valid), 32'(ev));
         chk("fetch_data",  fetch_data, ed);
         chk("cpu_hold",    32'(cpu_hold), 32'(hold));
         chk("load_ack",    32'(load_ack), 32'(ack_exp));
         chk("mem_en",      32'(mem_en), 32'(iss || wr));
         chk("mem_we",      32'(mem_we), 32'(wr));
         if (wr) begin
            chk("mem_addr_wr", 32'(mem_addr), 32'(load_addr));
            chk("mem_wdata",   mem_wdata, load_data);
         end else if (iss) begin
            chk("mem_addr_rd", 32'(mem_addr), 32'(fetch_addr[AW+1:2]));
         end

         no_reads = (inflight.size() == 0);
         if (ev) begin
            last_data = inflight[0].data;
            void'(inflight.pop_front());
         end
         if (iss) inflight.push_back('{cyc + LAT, ref_mem[fetch_addr[AW+1:2]]});
         if (wr) ref_mem[load_addr] = load_data;
         ack_exp = wr;
         case (mode)
            M_IDLE:  mode = load_req ? M_LOAD : (fetch_req ? M_FETCH : M_IDLE);
            M_FETCH: mode = load_req ? M_DRAIN : M_FETCH;
            M_DRAIN: mode = no_reads ? M_LOAD : M_DRAIN;
            default: mode = load_done ? M_IDLE : M_LOAD;
         endcase
      end
      cyc++;
   end

   task automatic cycle_end();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   logic [31:0] exp_persist [6];

   initial begin
      reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_req = 1'b0;
      load_addr = '0; load_data = '0; load_we = 1'b0; load_done = 1'b0;
      exp_persist = '{32'hAA00_0000, 32'hAA00_0001, 32'hAA00_0002,
                      32'hC0DE_0067, 32'hC0DE_0068, 32'hC0DE_0069};

      sample();
      chk("t0_reset_hold",  32'(cpu_hold), 32'd0);
      chk("t0_reset_valid", 32'(fetch_valid), 32'd0);
      cycle_end();
      cycle_end();
      reset = 1'b0;

      // streaming fetch of words 0,1,2
      fetch_req = 1'b1; fetch_addr = 32'h0;
      sample(); chk("t1_addr0", 32'(mem_addr), 32'd0); chk("t1_en", 32'(mem_en), 32'd1);
      cycle_end();
      fetch_addr = 32'h4;
      sample(); chk("t1_addr1", 32'(mem_addr), 32'd1);
      cycle_end();
      fetch_addr = 32'h8;
      sample(); chk("t1_addr2", 32'(mem_addr), 32'd2);
      chk("t1_v0", 32'(fetch_valid), 32'd1); chk("t1_d0", fetch_data, 32'hC0DE_0000);
      cycle_end();
      fetch_req = 1'b0;
      sample(); chk("t1_d1", fetch_data, 32'hC0DE_0001);
      cycle_end();
      sample(); chk("t1_v2", 32'(fetch_valid), 32'd1); chk("t1_d2", fetch_data, 32'hC0DE_0002);
      cycle_end();
      sample(); chk("t1_vnone", 32'(fetch_valid), 32'd0); chk("t1_dhold", fetch_data, 32'hC0DE_0002);
      cycle_end();

      // loader request during a stream: drain then LOAD
      fetch_req = 1'b1; fetch_addr = 32'h10;
      cycle_end();
      fetch_addr = 32'h14;
      cycle_end();
      fetch_addr = 32'h18; load_req = 1'b1;
      sample(); chk("t2_hold", 32'(cpu_hold), 32'd1); chk("t2_noissue", 32'(mem_en), 32'd0);
      chk("t2_d4", fetch_data, 32'hC0DE_0004);
      cycle_end();
      sample(); chk("t2_drain_v", 32'(fetch_valid), 32'd1); chk("t2_d5", fetch_data, 32'hC0DE_0005);
      cycle_end();
      sample(); chk("t2_drain_en", 32'(mem_en), 32'd0); chk("t2_drain_hold", 32'(cpu_hold), 32'd1);
      cycle_end();

      // write 0xDEADBEEF to word 5, then release
      fetch_req = 1'b0; load_we = 1'b1; load_addr = 10'd5; load_data = 32'hDEAD_BEEF;
      sample(); chk("t3_we", 32'(mem_we), 32'd1); chk("t3_addr", 32'(mem_addr), 32'd5);
      chk("t3_ack_early", 32'(load_ack), 32'd0);
      cycle_end();
      load_we = 1'b0;
      sample(); chk("t3_ack", 32'(load_ack), 32'd1);
      cycle_end();
      load_done = 1'b1; load_req = 1'b0;
      sample(); chk("t3_hold_done", 32'(cpu_hold), 32'd1);
      cycle_end();
      load_done = 1'b0;
      sample(); chk("t3_hold_drop", 32'(cpu_hold), 32'd0);
      cycle_end();

      // load_req and fetch_req together in IDLE
      load_req = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h14;
      sample(); chk("t4_hold", 32'(cpu_hold), 32'd1); chk("t4_en", 32'(mem_en), 32'd0);
      cycle_end();
      load_we = 1'b1; load_addr = 10'd6; load_data = 32'h1234_5678;
      sample(); chk("t4_we", 32'(mem_we), 32'd1); chk("t4_nofetch", 32'(fetch_valid), 32'd0);
      cycle_end();
      load_we = 1'b0; load_done = 1'b1; load_req = 1'b0; fetch_req = 1'b0;
      sample(); chk("t4_ack", 32'(load_ack), 32'd1); chk("t4_nofetch2", 32'(fetch_valid), 32'd0);
      cycle_end();
      load_done = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h14;
      sample(); chk("t3_refetch_addr", 32'(mem_addr), 32'd5);
      cycle_end();
      fetch_addr = 32'h18;
      cycle_end();
      fetch_req = 1'b0;
      sample(); chk("t3_readback", fetch_data, 32'hDEAD_BEEF);
      cycle_end();
      sample(); chk("t4_readback", fetch_data, 32'h1234_5678);
      cycle_end();

      // address wrap and write strobe outside LOAD
      fetch_req = 1'b1; fetch_addr = 32'h0000_1004;
      load_we = 1'b1; load_addr = 10'd7; load_data = 32'hBAD0_BAD0;
      sample(); chk("t6_wrap", 32'(mem_addr), 32'd1); chk("t6_nowe", 32'(mem_we), 32'd0);
      cycle_end();
      fetch_req = 1'b0; load_we = 1'b0;
      sample(); chk("t6_noack", 32'(load_ack), 32'd0);
      cycle_end();
      sample(); chk("t6_data", fetch_data, 32'hC0DE_0001);
      cycle_end();

      // reset in the middle of a six-word load
      load_req = 1'b1;
      cycle_end();
      cycle_end();
      for (int k = 0; k < 3; k++) begin
         load_we = 1'b1; load_addr = AW'(100 + k); load_data = 32'hAA00_0000 + 32'(k);
         sample(); chk("t5_we", 32'(mem_we), 32'd1);
         cycle_end();
      end
      load_addr = 10'd103; load_data = 32'hAA00_0003; reset = 1'b1;
      sample(); chk("t5_rst_we", 32'(mem_we), 32'd0); chk("t5_rst_hold", 32'(cpu_hold), 32'd0);
      cycle_end();
      cycle_end();
      reset = 1'b0; load_req = 1'b0; load_we = 1'b0;
      sample(); chk("t5_idle_hold", 32'(cpu_hold), 32'd0);
      cycle_end();
      cycle_end();
      for (int k = 0; k < 6; k++) begin
         chk("t5_persist", bram[100 + k], exp_persist[k]);
      end

      for (int i = 0; i < DEPTH; i++) begin
         chk("mem_image", bram[i], ref_mem[i]);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
